shift_ring_unit: RTL and testbench

Parametrised successor to the fixed 6-bit right-shift ring. It holds a WIDTH-bit register that can be parallel-loaded, then rotated or shifted in one of several modes for a programmed number of steps. A start/busy/done handshake sequences the steps. It sits beside the existing counter and ring blocks as the general-purpose shift/rotate element for sequencers and pattern generators.

---
 rtl/shift_ring_unit.sv | 120 ++++++++++++
 tb/tb_shift_ring_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_ring_unit.sv
// shift_ring_unit: WIDTH-bit load/rotate/shift register
// sequenced by a start/busy/done handshake over a programmed step count.
module shift_ring_unit #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             serial_in,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             start,
  output logic [WIDTH-1:0] number,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [2:0]       mode_q;
  logic [2:0]       mode_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [WIDTH-1:0] number_nx;
  logic             sout_nx;
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  // One step of the latched mode; 0 and 7 hold.
  always_comb begin
    step_val = number;
    step_out = 1'b0;
    case (mode_q)
      3'd1: begin
        step_val = {number[0], number[WIDTH-1:1]};
        step_out = number[0];
      end
      3'd2: begin
        step_val = {number[WIDTH-2:0], number[WIDTH-1]};
        step_out = number[WIDTH-1];
      end
      3'd3: begin
        step_val = {serial_in, number[WIDTH-1:1]};
        step_out = number[0];
      end
      3'd4: begin
        step_val = {number[WIDTH-2:0], serial_in};
        step_out = number[WIDTH-1];
      end
      3'd5: begin
        step_val = {~number[0], number[WIDTH-1:1]};
        step_out = number[0];
      end
      3'd6: begin
        step_val = {number[WIDTH-1], number[WIDTH-1:1]};
        step_out = number[0];
      end
      default: begin
        step_val = number;
        step_out = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nx  = state;
    mode_nx   = mode_q;
    cnt_nx    = cnt;
    number_nx = number;
    sout_nx   = serial_out;
    unique case (state)
      IDLE: begin
        if (load) begin
          number_nx = data_in;
        end else if (start) begin
          mode_nx  = mode;
          cnt_nx   = amount;
          state_nx = (amount == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        number_nx = step_val;
        sout_nx   = step_out;
        cnt_nx    = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state      <= IDLE;
      mode_q     <= '0;
      cnt        <= '0;
      number     <= '0;
      serial_out <= 1'b0;
    end else begin
      state      <= state_nx;
      mode_q     <= mode_nx;
      cnt        <= cnt_nx;
      number     <= number_nx;
      serial_out <= sout_nx;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_shift_ring_unit.sv
// tb_shift_ring_unit: scoreboard bench for shift_ring_unit
// (WIDTH=6); per-step results queued at start, checked as steps land.
module tb_shift_ring_unit;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       load = 1'b0;
  logic [5:0] data_in = '0;
  logic       serial_in = 1'b0;
  logic [2:0] mode = '0;
  logic [3:0] amount = '0;
  logic       start = 1'b0;
  logic [5:0] number;
  logic       serial_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] exp_q[$];
  logic [5:0] model_n;
  logic       busy_d = 1'b0;
  logic       rst_d = 1'b0;

  shift_ring_unit dut (
    .clk(clk),
    .clr_n(clr_n),
    .load(load),
    .data_in(data_in),
    .serial_in(serial_in),
    .mode(mode),
    .amount(amount),
    .start(start),
    .number(number),
    .serial_out(serial_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] step_fn(input logic [5:0] n,
                                         input logic [2:0] m,
                                         input logic s);
    logic [5:0] r;
    logic       o;
    r = n;
    o = 1'b0;
    case (m)
      3'd1: begin r = {n[0], n[5:1]}; o = n[0]; end
      3'd2: begin r = {n[4:0], n[5]}; o = n[5]; end
      3'd3: begin r = {s, n[5:1]}; o = n[0]; end
      3'd4: begin r = {n[4:0], s}; o = n[5]; end
      3'd5: begin r = {~n[0], n[5:1]}; o = n[0]; end
      3'd6: begin r = {n[5], n[5:1]}; o = n[0]; end
      default: begin r = n; o = 1'b0; end
    endcase
    return {o, r};
  endfunction

  // A step happened at the last edge iff the DUT was in RUN
  // and out of reset when that edge arrived.
  always @(negedge clk) begin
    logic [6:0] e;
    if (busy_d && rst_d) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("step", {serial_out, number}, e);
      end
    end
    busy_d = busy;
    rst_d  = clr_n;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [5:0] v);
    load    = 1'b1;
    data_in = v;
    cyc();
    load    = 1'b0;
    model_n = v;
    check("load", number, v);
  endtask

  task automatic run_op(input logic [2:0] m, input logic [3:0] k,
                        input logic s, input bit poke,
                        input logic [5:0] exp_final);
    int b;
    int d;
    int bd;
    logic [6:0] r;
    serial_in = s;
    mode      = m;
    amount    = k;
    start     = 1'b1;
    for (int i = 0; i < int'(k); i++) begin
      r = step_fn(model_n, m, s);
      model_n = r[5:0];
      exp_q.push_back(r);
    end
    cyc();
    start   = 1'b0;
    mode    = 3'($urandom);
    amount  = 4'($urandom);
    data_in = 6'($urandom);
    b = 0;
    d = 0;
    bd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      b += int'(busy);
      d += int'(done);
      if (busy && done) bd++;
      if (poke) begin
        load  = busy;
        start = busy;
      end
      if (done) break;
    end
    load  = 1'b0;
    start = 1'b0;
    cyc();
    check("busy_cycles", b, k);
    check("done_pulses", d, 1);
    check("busy_done_excl", bd, 0);
    check("sb_drained", exp_q.size(), 0);
    check("final", number, exp_final);
    check("idle_after", {busy, done}, 0);
  endtask

  initial begin
    int d;
    clr_n = 1'b0;
    cyc();
    cyc();
    check("rst_number", number, 6'b000000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sout", serial_out, 0);
    clr_n = 1'b1;

    do_load(6'b000001);
    run_op(3'd1, 4'd1, 1'b0, 1'b0, 6'b100000);
    check("rotr_sout", serial_out, 1);

    do_load(6'b100101);
    run_op(3'd2, 4'd3, 1'b0, 1'b0, 6'b101100);

    do_load(6'b000000);
    run_op(3'd5, 4'd12, 1'b0, 1'b0, 6'b000000);

    do_load(6'b100100);
    run_op(3'd6, 4'd2, 1'b0, 1'b0, 6'b111001);

    do_load(6'b000000);
    run_op(3'd4, 4'd3, 1'b1, 1'b0, 6'b000111);

    do_load(6'b101010);
    run_op(3'd1, 4'd0, 1'b0, 1'b0, 6'b101010);

    do_load(6'b110010);
    run_op(3'd1, 4'd6, 1'b0, 1'b0, 6'b110010);

    do_load(6'b011001);
    run_op(3'd1, 4'd3, 1'b0, 1'b1, 6'b001011);

    do_load(6'b101101);
    run_op(3'd3, 4'd9, 1'b0, 1'b0, 6'b000000);

    // load and start together in IDLE
    load    = 1'b1;
    start   = 1'b1;
    data_in = 6'b010101;
    mode    = 3'd1;
    amount  = 4'd2;
    cyc();
    load  = 1'b0;
    start = 1'b0;
    model_n = 6'b010101;
    check("ls_number", number, 6'b010101);
    check("ls_busy", busy, 0);
    cyc();
    check("ls_idle", {busy, done}, 0);
    check("ls_hold", number, 6'b010101);

    // reset in the middle of an 8-step rotate
    do_load(6'b111000);
    serial_in = 1'b0;
    mode      = 3'd1;
    amount    = 4'd8;
    start     = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [6:0] r;
      r = step_fn(model_n, 3'd1, 1'b0);
      model_n = r[5:0];
      exp_q.push_back(r);
    end
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    clr_n = 1'b0;
    cyc();
    exp_q.delete();
    clr_n = 1'b1;
    check("mid_rst_number", number, 6'b000000);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_sout", serial_out, 0);
    d = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d += int'(done);
    end
    check("mid_rst_no_done", d, 0);
    cyc();

    do_load(6'b000011);
    run_op(3'd2, 4'd2, 1'b0, 1'b0, 6'b001100);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
